// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - radix-4 digit-serial two's complement subtractor with valid/ready handshakes
// Optional borrow input port enabled by defining SERIAL_SUBTRACTOR_BORROW_IN_EN.
module serial_subtractor #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  input  logic         bin,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         borrow,
  output logic         overflow_flag,
  output logic         negative
);

  localparam int CW = $clog2(N / 2);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N / 2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, next_state;

  logic [N-1:0]  a_q, b_q, sum_q, result_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q, cmid_q;
  logic          borrow_q, ovf_q, neg_q, out_valid_q;
  logic          accept, release_res;
  logic          last_digit;
  logic          carry_init;
  logic [1:0]    lo, hi;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  assign carry_init = ~bin;
`else
  assign carry_init = 1'b1;
`endif

  always_comb begin
    next_state  = state_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_DIGIT) next_state = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          release_res = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= next_state;
  end

  assign last_digit = (state_q == RUN) && (cnt_q == LAST_DIGIT);

  // Split the digit add so the carry out of the lower bit (into the top bit on the last digit) is visible.
  always_comb begin
    lo = {1'b0, a_q[0]} + {1'b0, b_q[0]} + {1'b0, carry_q};
    hi = {1'b0, a_q[1]} + {1'b0, b_q[1]} + {1'b0, lo[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cmid_q      <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= A;
        b_q     <= ~B;
        carry_q <= carry_init;
        cnt_q   <= '0;
      end
      if (state_q == RUN) begin
        a_q     <= a_q >> 2;
        b_q     <= b_q >> 2;
        sum_q   <= {hi[0], lo[0], sum_q[N-1:2]};
        carry_q <= hi[1];
        cnt_q   <= cnt_q + CW'(1);
        if (last_digit) cmid_q <= lo[1];
      end
      // Results are published one cycle into DONE so outputs only change when a new result is complete.
      if (state_q == DONE && !out_valid_q) begin
        result_q    <= sum_q;
        borrow_q    <= ~carry_q;
        ovf_q       <= carry_q ^ cmid_q;
        neg_q       <= carry_q ^ cmid_q ^ sum_q[N-1];
        out_valid_q <= 1'b1;
      end
      if (release_res) out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign borrow        = borrow_q;
  assign overflow_flag = ovf_q;
  assign negative      = neg_q;

endmodule
